// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux: one-hot grant plus 3-bit select, 1-cycle registered latency.
// Hold limit bounds ownership under contention; en=0 freezes new grants and preemption.
module mux8_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] sel_q, sel_d;
   logic       busy_q, busy_d;
   logic [7:0] others;
   logic [2:0] next_start;

   // First set bit at or after p, wrapping; descending loop so the nearest offset wins.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] w;
      logic [2:0] idx;
      w = p;
      for (int i = 7; i >= 0; i--) begin
         idx = p + 3'(i);
         if (r[idx]) w = idx;
      end
      return w;
   endfunction

   assign others     = req & ~gnt_q;
   assign next_start = sel_q + 3'd1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (en && (req != 8'd0)) begin
               sel_d   = rr_pick(req, ptr_q);
               gnt_d   = 8'd1 << rr_pick(req, ptr_q);
               busy_d  = 1'b1;
               cnt_d   = 4'd1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // sel_q always names the current owner while granted.
            if (!req[sel_q]) begin
               ptr_d = next_start;
               if (en && (others != 8'd0)) begin
                  sel_d = rr_pick(others, next_start);
                  gnt_d = 8'd1 << rr_pick(others, next_start);
                  cnt_d = 4'd1;
               end else begin
                  gnt_d   = 8'd0;
                  busy_d  = 1'b0;
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end
            end else if (en && (cnt_q == HOLD_MAX) && (others != 8'd0)) begin
               ptr_d = next_start;
               sel_d = rr_pick(others, next_start);
               gnt_d = 8'd1 << rr_pick(others, next_start);
               cnt_d = 4'd1;
            end else if (cnt_q != HOLD_MAX) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         cnt_q   <= 4'd0;
         gnt_q   <= 8'd0;
         sel_q   <= 3'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboarded random bench for mux8_rr_arbiter with hold limits 4 and 1 driven by shared stimulus.
module tb_mux8_rr_arbiter;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
   } out_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [7:0] gnt0, gnt1;
   logic [2:0] sel0, sel1;
   logic       busy0, busy1;

   int errors = 0;
   int checks = 0;

   out_t q0[$];
   out_t q1[$];

   // Reference state: owner index (-1 idle), pointer, hold count, last select.
   int m_owner[2];
   int m_ptr[2];
   int m_hold[2];
   int m_sel[2];
   int m_lim[2];

   mux8_rr_arbiter #(.MAX_HOLD(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt0), .sel(sel0), .busy(busy0)
   );

   mux8_rr_arbiter #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt1), .sel(sel1), .busy(busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int search(input logic [7:0] r, input int p);
      for (int i = 0; i < 8; i++)
         if (r[(p + i) % 8]) return (p + i) % 8;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1;
         m_ptr[d]   = 0;
         m_hold[d]  = 0;
         m_sel[d]   = 0;
      end
   endtask

   task automatic model_step(input int d, input logic [7:0] r, input logic e);
      logic [7:0] rest;
      if (m_owner[d] < 0) begin
         if (e && r != 8'd0) begin
            m_owner[d] = search(r, m_ptr[d]);
            m_hold[d]  = 1;
            m_sel[d]   = m_owner[d];
         end
      end else begin
         rest = r;
         rest[m_owner[d]] = 1'b0;
         if (!r[m_owner[d]]) begin
            m_ptr[d] = (m_owner[d] + 1) % 8;
            if (e && rest != 8'd0) begin
               m_owner[d] = search(rest, m_ptr[d]);
               m_hold[d]  = 1;
               m_sel[d]   = m_owner[d];
            end else begin
               m_owner[d] = -1;
            end
         end else if (e && m_hold[d] >= m_lim[d] && rest != 8'd0) begin
            m_ptr[d]   = (m_owner[d] + 1) % 8;
            m_owner[d] = search(rest, m_ptr[d]);
            m_hold[d]  = 1;
            m_sel[d]   = m_owner[d];
         end else if (m_hold[d] < m_lim[d]) begin
            m_hold[d]++;
         end
      end
   endtask

   function automatic out_t model_out(input int d);
      out_t o;
      o.gnt  = (m_owner[d] < 0) ? 8'd0 : (8'd1 << m_owner[d]);
      o.sel  = 3'(m_sel[d]);
      o.busy = (m_owner[d] >= 0);
      return o;
   endfunction

   // Drive one cycle of stimulus and queue what each DUT must show after the next edge.
   task automatic cycle(input logic [7:0] r, input logic e);
      @(negedge clk);
      req = r;
      en  = e;
      for (int d = 0; d < 2; d++) model_step(d, r, e);
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_gnt0", 32'(gnt0), 32'h0);
      check("rst_sel0", 32'(sel0), 32'h0);
      check("rst_busy0", 32'(busy0), 32'h0);
      check("rst_gnt1", 32'(gnt1), 32'h0);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: pops one expected entry per clock edge and compares.
   initial begin
      out_t e0, e1;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && q0.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check("gnt_h4", 32'(gnt0), 32'(e0.gnt));
            check("sel_h4", 32'(sel0), 32'(e0.sel));
            check("busy_h4", 32'(busy0), 32'(e0.busy));
            check("gnt_h1", 32'(gnt1), 32'(e1.gnt));
            check("sel_h1", 32'(sel1), 32'(e1.sel));
            check("busy_h1", 32'(busy1), 32'(e1.busy));
            check("onehot_h4", 32'($onehot0(gnt0)), 32'h1);
         end
      end
   end

   initial begin
      logic [7:0] r;
      m_lim[0] = 4;
      m_lim[1] = 1;
      model_reset();
      rst_n = 1'b1;
      en    = 1'b0;
      req   = 8'hFF;
      #1 rst_n = 1'b0;
      #2;
      check("init_gnt", 32'(gnt0), 32'h0);
      check("init_sel", 32'(sel0), 32'h0);
      check("init_busy", 32'(busy0), 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // First grant after reset goes to requester 0.
      cycle(8'hFF, 1'b1);
      cycle(8'h00, 1'b1);
      // Lone requester 5 holds with no preemption, then releases.
      repeat (10) cycle(8'h20, 1'b1);
      cycle(8'h00, 1'b1);
      // Two contenders rotate on the hold limit.
      repeat (14) cycle(8'h81, 1'b1);
      cycle(8'h00, 1'b1);
      // Back-to-back handover and wrapped search.
      cycle(8'h04, 1'b1);
      cycle(8'h44, 1'b1);
      cycle(8'h40, 1'b1);
      cycle(8'h80, 1'b1);
      cycle(8'h09, 1'b1);
      cycle(8'h00, 1'b1);
      // en=0 blocks preemption and regrant on release.
      cycle(8'h08, 1'b1);
      repeat (8) cycle(8'h0A, 1'b0);
      cycle(8'h02, 1'b0);
      cycle(8'h02, 1'b0);
      cycle(8'h02, 1'b1);
      cycle(8'h02, 1'b1);
      // Asynchronous reset mid-grant, then restart from pointer 0.
      pulse_reset();
      cycle(8'h10, 1'b1);
      cycle(8'h00, 1'b1);

      r = 8'h00;
      for (int n = 0; n < 2000; n++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         cycle(r, ($urandom_range(0, 9) != 0));
         if ($urandom_range(0, 399) == 0) pulse_reset();
      end

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(q0.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
